// File: rtl/buf_ctrl_pkg.sv
// Shared state encoding, mode codes and requester ids for the buffer arbiter.
package buf_ctrl_pkg;
   typedef enum logic [2:0] {CLR, IDLE, WR, RD, RDW} state_t;

   localparam logic MODE_FIFO = 1'b0;
   localparam logic MODE_LIFO = 1'b1;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant among eligible inputs,
// pointer hands priority to the other requester after every accepted grant.
module rr_arb2 (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [1:0] eligible,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr
);
   logic ptr_q;

   always_comb begin
      grant = 2'b00;
      if (ptr_q == 1'b0) begin
         if (eligible[0])      grant = 2'b01;
         else if (eligible[1]) grant = 2'b10;
      end else begin
         if (eligible[1])      grant = 2'b10;
         else if (eligible[0]) grant = 2'b01;
      end
   end

   // Granting requester 0 makes requester 1 the favourite, and vice versa.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                   ptr_q <= 1'b0;
      else if (advance && |grant)  ptr_q <= grant[0];
   end

   assign ptr = ptr_q;
endmodule

// File: rtl/buffer_arbiter.sv
// Shares one LIFO/FIFO buffer between two requesters; grant+strobe one cycle after an idle request,
// read data RD_LAT+2 cycles after it. Ineligible requests just wait; all outputs are registered.
module buffer_arbiter
   import buf_ctrl_pkg::*;
#(
   parameter int DW     = 8,
   parameter int DEPTH  = 8,
   parameter int RD_LAT = 1
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       REQ_WR0,
   input  logic                       REQ_WR1,
   input  logic                       REQ_RD0,
   input  logic                       REQ_RD1,
   input  logic [DW-1:0]              WDATA0,
   input  logic [DW-1:0]              WDATA1,
   output logic                       GNT0,
   output logic                       GNT1,
   output logic [DW-1:0]              RDATA0,
   output logic [DW-1:0]              RDATA1,
   output logic                       RVALID0,
   output logic                       RVALID1,
   input  logic                       MODE_SEL,
   output logic                       MODE_ACK,
   output logic                       BUF_RST,
   output logic                       BUF_WRN,
   output logic                       BUF_REN,
   output logic [DW-1:0]              BUF_IN,
   output logic                       BUF_LIFO,
   output logic                       BUF_FIFO,
   input  logic [DW-1:0]              BUF_OUT,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       FULL,
   output logic                       EMPTY
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t        state_q;
   logic          mode_q, rd_who_q, mode_ack_q, buf_rst_q, buf_wrn_q, buf_ren_q;
   logic          full_q, empty_q;
   logic [1:0]    gnt_q, rvalid_q;
   logic [DW-1:0] rdata0_q, rdata1_q, buf_in_q;
   logic [CW-1:0] count_q;
   logic [LW-1:0] lat_q;

   logic          pending, advance, win, win_wr, arb_ptr;
   logic [1:0]    wr_elig, rd_elig, grant;
   logic [DW-1:0] win_data;

   always_comb begin
      pending  = (MODE_SEL != mode_q);
      wr_elig  = {REQ_WR1, REQ_WR0} & {2{~full_q & ~pending}};
      rd_elig  = {REQ_RD1, REQ_RD0} & {2{~empty_q}};
      advance  = (state_q == IDLE) && !(pending && count_q == '0) && (|(wr_elig | rd_elig));
      win      = grant[1] ? REQ1 : REQ0;
      win_wr   = wr_elig[win];
      win_data = win ? WDATA1 : WDATA0;
   end

   rr_arb2 u_arb (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .eligible (wr_elig | rd_elig),
      .advance  (advance),
      .grant    (grant),
      .ptr      (arb_ptr)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= CLR;
         mode_q     <= MODE_FIFO;
         rd_who_q   <= REQ0;
         mode_ack_q <= 1'b0;
         buf_rst_q  <= 1'b1;
         buf_wrn_q  <= 1'b0;
         buf_ren_q  <= 1'b0;
         buf_in_q   <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         gnt_q      <= '0;
         rvalid_q   <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         count_q    <= '0;
         lat_q      <= '0;
      end else begin
         gnt_q      <= '0;
         rvalid_q   <= '0;
         mode_ack_q <= 1'b0;
         buf_rst_q  <= 1'b0;
         buf_wrn_q  <= 1'b0;
         buf_ren_q  <= 1'b0;
         case (state_q)
            CLR: begin
               count_q <= '0;
               full_q  <= 1'b0;
               empty_q <= 1'b1;
               state_q <= IDLE;
               if (pending) begin
                  mode_q     <= MODE_SEL;
                  mode_ack_q <= 1'b1;
               end
            end
            IDLE: begin
               // A drained buffer with a pending mode change goes to clear before anything else.
               if (pending && count_q == '0) begin
                  state_q   <= CLR;
                  buf_rst_q <= 1'b1;
               end else if (advance) begin
                  gnt_q    <= grant;
                  rd_who_q <= win;
                  if (win_wr) begin
                     state_q   <= WR;
                     buf_wrn_q <= 1'b1;
                     buf_in_q  <= win_data;
                  end else begin
                     state_q   <= RD;
                     buf_ren_q <= 1'b1;
                  end
               end
            end
            WR: begin
               count_q <= count_q + 1'b1;
               full_q  <= (count_q == CW'(DEPTH-1));
               empty_q <= 1'b0;
               state_q <= IDLE;
            end
            RD: begin
               count_q <= count_q - 1'b1;
               full_q  <= 1'b0;
               empty_q <= (count_q == CW'(1));
               lat_q   <= '0;
               state_q <= RDW;
            end
            RDW: begin
               if (lat_q == LW'(RD_LAT-1)) begin
                  if (rd_who_q == REQ1) rdata1_q <= BUF_OUT;
                  else                  rdata0_q <= BUF_OUT;
                  rvalid_q[rd_who_q] <= 1'b1;
                  state_q            <= IDLE;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            default: state_q <= CLR;
         endcase
      end
   end

   assign GNT0     = gnt_q[0];
   assign GNT1     = gnt_q[1];
   assign RVALID0  = rvalid_q[0];
   assign RVALID1  = rvalid_q[1];
   assign RDATA0   = rdata0_q;
   assign RDATA1   = rdata1_q;
   assign MODE_ACK = mode_ack_q;
   assign BUF_RST  = buf_rst_q;
   assign BUF_WRN  = buf_wrn_q;
   assign BUF_REN  = buf_ren_q;
   assign BUF_IN   = buf_in_q;
   assign BUF_LIFO = (mode_q == MODE_LIFO);
   assign BUF_FIFO = (mode_q == MODE_FIFO);
   assign COUNT    = count_q;
   assign FULL     = full_q;
   assign EMPTY    = empty_q;

   a_no_inc_full:  assert property (@(posedge CLK) disable iff (!RSTN)
                                    (state_q == WR) |-> (count_q != CW'(DEPTH)));
   a_no_dec_empty: assert property (@(posedge CLK) disable iff (!RSTN)
                                    (state_q == RD) |-> (count_q != '0));
   a_ptr_moves:    assert property (@(posedge CLK) disable iff (!RSTN)
                                    advance |=> (arb_ptr != rd_who_q));
endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: external LIFO/FIFO buffer model, read-data scoreboard, directed scenarios.
module tb_buffer_arbiter;
   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   logic       REQ_WR0 = 0, REQ_WR1 = 0, REQ_RD0 = 0, REQ_RD1 = 0;
   logic [7:0] WDATA0 = 0, WDATA1 = 0;
   logic       GNT0, GNT1, RVALID0, RVALID1, MODE_ACK;
   logic [7:0] RDATA0, RDATA1, BUF_IN;
   logic       MODE_SEL = 1'b0;
   logic       BUF_RST, BUF_WRN, BUF_REN, BUF_LIFO, BUF_FIFO, FULL, EMPTY;
   logic [7:0] BUF_OUT = 8'h00;
   logic [3:0] COUNT;

   int checks = 0, errors = 0;
   int cyc = 0;
   int rst_cyc = -1;
   logic [7:0] bq[$];
   logic [7:0] exp0[$], exp1[$];
   int gq0[$], gq1[$];

   int rc, gc, n, ack_cyc, rc2, gc2, bad;

   buffer_arbiter dut (
      .CLK(CLK), .RSTN(RSTN),
      .REQ_WR0(REQ_WR0), .REQ_WR1(REQ_WR1), .REQ_RD0(REQ_RD0), .REQ_RD1(REQ_RD1),
      .WDATA0(WDATA0), .WDATA1(WDATA1),
      .GNT0(GNT0), .GNT1(GNT1),
      .RDATA0(RDATA0), .RDATA1(RDATA1), .RVALID0(RVALID0), .RVALID1(RVALID1),
      .MODE_SEL(MODE_SEL), .MODE_ACK(MODE_ACK),
      .BUF_RST(BUF_RST), .BUF_WRN(BUF_WRN), .BUF_REN(BUF_REN), .BUF_IN(BUF_IN),
      .BUF_LIFO(BUF_LIFO), .BUF_FIFO(BUF_FIFO), .BUF_OUT(BUF_OUT),
      .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // External buffer: one-cycle registered read, cleared by BUF_RST.
   always @(posedge CLK) begin
      if (BUF_RST) begin
         bq.delete();
      end else begin
         if (BUF_WRN) begin
            chk("buf_overflow", int'(bq.size() < 8), 1);
            bq.push_back(BUF_IN);
         end
         if (BUF_REN) begin
            chk("buf_underflow", int'(bq.size() > 0), 1);
            if (bq.size() > 0) BUF_OUT <= BUF_LIFO ? bq.pop_back() : bq.pop_front();
         end
      end
   end

   // Scoreboard monitor: read data and its cycle relative to the grant.
   always @(negedge CLK) begin
      if (BUF_RST) rst_cyc = cyc;
      if (GNT0 | GNT1 | BUF_WRN | BUF_REN) begin
         chk("gnt_onehot", int'(GNT0) + int'(GNT1), 1);
         chk("strobe_onehot", int'(BUF_WRN) + int'(BUF_REN), 1);
      end
      if (RVALID0) begin
         if (exp0.size() == 0) chk("rvalid0_unexpected", 1, 0);
         else begin
            chk("rdata0", RDATA0, exp0.pop_front());
            chk("rvalid0_cycle", cyc, gq0.pop_front() + 2);
         end
      end
      if (RVALID1) begin
         if (exp1.size() == 0) chk("rvalid1_unexpected", 1, 0);
         else begin
            chk("rdata1", RDATA1, exp1.pop_front());
            chk("rvalid1_cycle", cyc, gq1.pop_front() + 2);
         end
      end
   end

   task automatic check_rst(input string p);
      chk({p, "_count"}, COUNT, 0);
      chk({p, "_empty"}, EMPTY, 1);
      chk({p, "_full"}, FULL, 0);
      chk({p, "_buf_rst"}, BUF_RST, 1);
      chk({p, "_buf_fifo"}, BUF_FIFO, 1);
      chk({p, "_buf_lifo"}, BUF_LIFO, 0);
      chk({p, "_gnt"}, {GNT1, GNT0}, 0);
      chk({p, "_rvalid"}, {RVALID1, RVALID0}, 0);
      chk({p, "_strobes"}, {BUF_WRN, BUF_REN}, 0);
      chk({p, "_mode_ack"}, MODE_ACK, 0);
      chk({p, "_rdata0"}, RDATA0, 0);
      chk({p, "_rdata1"}, RDATA1, 0);
   endtask

   task automatic do_reset(input bit with_check);
      @(posedge CLK); #1;
      RSTN = 0; REQ_WR0 = 0; REQ_WR1 = 0; REQ_RD0 = 0; REQ_RD1 = 0;
      @(negedge CLK);
      if (with_check) check_rst("reset");
      @(posedge CLK); #1;
      RSTN = 1;
   endtask

   task automatic wait_gnt(input int r, output int g);
      g = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if ((r == 0 && GNT0) || (r == 1 && GNT1)) begin
            g = cyc;
            break;
         end
      end
      if (g < 0) begin
         checks++; errors++;
         $display("FAIL gnt_timeout: requester %0d saw no grant within 200 cycles", r);
      end
   endtask

   task automatic wr(input int r, input logic [7:0] d, output int rcyc, output int g);
      @(posedge CLK); #1;
      if (r == 0) begin REQ_WR0 = 1; WDATA0 = d; end
      else        begin REQ_WR1 = 1; WDATA1 = d; end
      rcyc = cyc;
      wait_gnt(r, g);
      @(posedge CLK); #1;
      if (r == 0) REQ_WR0 = 0; else REQ_WR1 = 0;
   endtask

   task automatic rd(input int r, input logic [7:0] expd, output int rcyc, output int g);
      @(posedge CLK); #1;
      if (r == 0) begin REQ_RD0 = 1; exp0.push_back(expd); end
      else        begin REQ_RD1 = 1; exp1.push_back(expd); end
      rcyc = cyc;
      wait_gnt(r, g);
      if (r == 0) gq0.push_back(g); else gq1.push_back(g);
      @(posedge CLK); #1;
      if (r == 0) REQ_RD0 = 0; else REQ_RD1 = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // FIFO round trip with latency checks.
      do_reset(1);
      wr(0, 8'd100, rc, gc);
      chk("t1_wr_gnt_latency", gc, rc + 1);
      wr(0, 8'd150, rc, gc);
      wr(0, 8'd200, rc, gc);
      chk("t1_count_after_wr", COUNT, 3);
      rd(1, 8'd100, rc, gc);
      chk("t1_rd_gnt_latency", gc, rc + 1);
      rd(1, 8'd150, rc, gc);
      rd(1, 8'd200, rc, gc);
      repeat (4) @(posedge CLK); #1;
      chk("t1_count_end", COUNT, 0);
      chk("t1_empty_end", EMPTY, 1);
      chk("t1_sb_drained", exp1.size(), 0);

      // Both requesters write continuously: alternate grants, stop at full.
      do_reset(0);
      @(posedge CLK); #1;
      REQ_WR0 = 1; WDATA0 = 8'h11; REQ_WR1 = 1; WDATA1 = 8'h22;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (GNT0 | GNT1) begin
            chk("t2_gnt_order", GNT1, n % 2);
            n++;
         end
      end
      chk("t2_num_grants", n, 8);
      chk("t2_full", FULL, 1);
      chk("t2_count", COUNT, 8);
      @(posedge CLK); #1;
      REQ_WR0 = 0; REQ_WR1 = 0;
      for (int k = 0; k < 8; k++) rd(0, (k % 2 == 0) ? 8'h11 : 8'h22, rc, gc);
      repeat (4) @(posedge CLK); #1;
      chk("t2_empty_end", EMPTY, 1);

      // FIFO -> LIFO: writes blocked while draining, clear, ack, then LIFO order.
      do_reset(0);
      wr(0, 8'd1, rc, gc);
      wr(0, 8'd2, rc, gc);
      wr(0, 8'd3, rc, gc);
      @(posedge CLK); #1;
      MODE_SEL = 1;
      ack_cyc = -1;
      fork
         wr(0, 8'd99, rc2, gc2);
         begin
            rd(1, 8'd1, rc, gc);
            rd(1, 8'd2, rc, gc);
            rd(1, 8'd3, rc, gc);
            for (int k = 0; k < 50; k++) begin
               @(negedge CLK);
               if (MODE_ACK) begin
                  ack_cyc = cyc;
                  break;
               end
            end
            if (ack_cyc < 0) begin
               checks++; errors++;
               $display("FAIL t3_ack_timeout: no MODE_ACK within 50 cycles");
            end else begin
               chk("t3_clr_before_ack", rst_cyc, ack_cyc - 1);
               chk("t3_lifo", BUF_LIFO, 1);
               chk("t3_fifo", BUF_FIFO, 0);
               @(negedge CLK);
               chk("t3_ack_pulse", MODE_ACK, 0);
            end
         end
      join
      chk("t3_write_after_ack", gc2, ack_cyc + 1);
      wr(0, 8'd40, rc, gc);
      wr(0, 8'd70, rc, gc);
      wr(0, 8'd65, rc, gc);
      rd(1, 8'd65, rc, gc);
      rd(1, 8'd70, rc, gc);
      rd(1, 8'd40, rc, gc);
      rd(1, 8'd99, rc, gc);
      repeat (4) @(posedge CLK); #1;
      chk("t3_count_end", COUNT, 0);

      // Read on empty waits until another requester writes.
      MODE_SEL = 0;
      do_reset(0);
      bad = 0;
      fork
         rd(0, 8'h5A, rc, gc);
         begin
            for (int k = 0; k < 6; k++) begin
               @(negedge CLK);
               if (GNT0 | BUF_REN) bad = 1;
            end
            chk("t4_no_gnt_when_empty", bad, 0);
            wr(1, 8'h5A, rc2, gc2);
         end
      join
      chk("t4_read_after_write", int'(gc > gc2), 1);
      repeat (4) @(posedge CLK); #1;
      chk("t4_sb_drained", exp0.size(), 0);

      // Reset during RDW: no RVALID, everything back to reset values at once.
      wr(0, 8'h33, rc, gc);
      wr(0, 8'h44, rc, gc);
      @(posedge CLK); #1;
      REQ_RD1 = 1;
      wait_gnt(1, gc);
      @(posedge CLK); #1;
      REQ_RD1 = 0;
      RSTN = 0;
      #1;
      check_rst("t5_midread");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RSTN = 1;
      #1;
      chk("t5_buf_rst_held", BUF_RST, 1);
      @(posedge CLK); #1;
      chk("t5_buf_rst_released", BUF_RST, 0);
      repeat (5) @(posedge CLK); #1;
      chk("t5_count", COUNT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
